icache_refill: RTL
==================

Name: icache_refill

Overview:
- Refill engine on the far side of the instruction cache's fill interface.
- When the cache reports a miss, it fetches the whole 16-byte block containing the missing instruction from the byte-wide unified RAM port, one byte per granted cycle.
- It then presents the assembled block to the cache as a single-cycle fill.
- It sits between the instruction cache and the memory arbiter.

Parameters:
- ADDR_WIDTH, 17, byte address width.
- BLOCK_WIDTH, 4, log2 of block size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH, bytes per cache block.

Ports:
- clkIn  input  1  system clock.
- resetIn  input  1  synchronous, active-high reset.
- missIn  input  1  cache miss for the current fetch address.
- instrAddrIn  input  ADDR_WIDTH  fetch address that missed.
- memGrantIn  input  1  arbiter grants the RAM port this cycle.
- ramDataIn  input  8  RAM read byte; valid one cycle after a granted request.
- memReqOut  output  1  requests the RAM port.
- ramAddrOut  output  ADDR_WIDTH  byte address being read.
- memDataValid  output  1  one-cycle fill strobe to the cache.
- memAddr  output  ADDR_WIDTH-BLOCK_WIDTH  block address of the fill, bits [ADDR_WIDTH-1:BLOCK_WIDTH].
- memDataOut  output  BLOCK_SIZE*8  filled block; byte k at [8k+7:8k].
- busyOut  output  1  a refill is in progress (any state other than IDLE).

Behaviour:
- One clock (clkIn). Synchronous, active-high reset (resetIn). Reset is sampled only at the posedge.
- Reset values: state IDLE; memReqOut 0; ramAddrOut 0; memDataValid 0; memAddr 0; memDataOut 0; busyOut 0; both counters 0.
- States: IDLE, FETCH, DRAIN, FILL, COOL.
- IDLE:
  - On missIn=1, latch blockAddr = instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH].
  - Clear issueCnt and recvCnt; go to FETCH.
  - instrAddrIn is ignored in every other state.
- FETCH:
  - memReqOut=1 and ramAddrOut={blockAddr, issueCnt}.
  - A byte is issued in a cycle where memReqOut && memGrantIn. On issue, issueCnt increments.
  - When the issue of byte BLOCK_SIZE-1 occurs, go to DRAIN.
  - If memGrantIn=0, hold the address and count (stall). There is no timeout.
- Receive path (active in FETCH and DRAIN):
  - A 1-bit issued-last-cycle flag is registered.
  - When the flag is set, write ramDataIn into byte slot recvCnt of the assembly buffer and increment recvCnt.
  - In-flight data is captured even if the grant drops in the following cycle.
- DRAIN:
  - memReqOut=0.
  - When the final byte is captured (recvCnt reaches BLOCK_SIZE), go to FILL.
- FILL (exactly one cycle):
  - memDataValid=1, memAddr=blockAddr, memDataOut=assembly buffer.
  - Next state: COOL.
- COOL (one cycle):
  - Ignore missIn. The cache writes at the end of the FILL cycle, but its combinational miss is still high during the FILL cycle and must not retrigger a refill of the same block.
  - Next state: IDLE.
- Latency for an uncontended miss: missIn in IDLE at cycle 0 → first request in cycle 1 → last request in cycle 16 → last byte captured at the end of cycle 17 → memDataValid in cycle 18 → COOL in cycle 19 → IDLE in cycle 20.
- Counters:
  - issueCnt and recvCnt are BLOCK_WIDTH+1 bits wide.
  - The low BLOCK_WIDTH bits index the byte. No wrap inside a block; the block base is always aligned.
- memDataOut and memAddr hold their last values outside FILL. Consumers must qualify them with memDataValid.
- memReqOut is 0 in every state other than FETCH.
- Reset mid-refill: return to IDLE next cycle. Discard partial data. Do not emit memDataValid.
- missIn and memGrantIn are don't-care in IDLE unless stated. memGrantIn is ignored outside FETCH.

Decomposition:
- Shared package holds:
  - The state encoding: IDLE=0, FETCH=1, DRAIN=2, FILL=3, COOL=4.
  - The ADDR_WIDTH, BLOCK_WIDTH and BLOCK_SIZE defaults, shared with the cache.
- The byte-to-block assembly buffer (write-enable, byte index, byte in, block out) is a natural sub-module: block_assembler.

Test Plan:
- Basic refill: missIn=1 with instrAddrIn=0x01234, grant always 1, RAM returns byte = low address byte.
  - ramAddrOut sequences 0x01230..0x0123F.
  - memDataValid pulses once in cycle 18 with memAddr=0x0123 and memDataOut=0x3F3E...3130.
- Stalled grant: grant toggles 1,0,1,0...
  - No address is skipped or repeated.
  - 16 captures occur; the fill content is identical to the basic case.
  - memDataValid is delayed by exactly the number of denied FETCH cycles.
- Miss held high through the fill: missIn stays 1 for the whole transaction.
  - Only one memDataValid pulse.
  - memReqOut stays 0 during COOL.
  - A new refill starts only from IDLE, in the cycle after COOL.
- Back-to-back misses: second miss at 0x00050 asserted immediately after COOL.
  - Second refill reads 0x00050..0x0005F.
  - memAddr=0x0005.
- Reset mid-refill: assert resetIn after the 7th byte is issued.
  - Next cycle: memReqOut=0, busyOut=0, and no memDataValid.
  - A subsequent miss refetches from byte 0.
- Grant dropped on the last issue: grant=1 for bytes 0–15, then 0.
  - The final byte, arriving in the cycle after its issue, is still captured.
  - FILL occurs normally.

Source files
------------

// File: rtl/icache_refill_pkg.sv
// icache_refill_pkg: shared state encoding and block geometry defaults for the icache refill engine
package icache_refill_pkg;
  localparam int ADDR_WIDTH_DEF = 17;
  localparam int BLOCK_WIDTH_DEF = 4;
  localparam int BLOCK_SIZE_DEF = 2 ** BLOCK_WIDTH_DEF;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    FILL  = 3'd3,
    COOL  = 3'd4
  } state_e;
endpackage

// File: rtl/icache_refill_assembler.sv
// block_assembler: byte-wide writes into a block buffer (clk_i, rst_i, we_i, idx_i byte slot, byte_i, block_o with byte k at [8k+7:8k])
module block_assembler import icache_refill_pkg::*; #(
  parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
  parameter int BLOCK_SIZE = 2 ** BLOCK_WIDTH
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    we_i,
  input  logic [BLOCK_WIDTH-1:0]  idx_i,
  input  logic [7:0]              byte_i,
  output logic [BLOCK_SIZE*8-1:0] block_o
);
  logic [BLOCK_SIZE-1:0][7:0] mem_q;
  always_ff @(posedge clk_i) begin
    if (rst_i) mem_q <= '0;
    else if (we_i) mem_q[idx_i] <= byte_i;
  end
  assign block_o = mem_q;
endmodule

// File: rtl/icache_refill.sv
// icache_refill: on missIn fetch the 16-byte block byte-by-byte over the granted RAM port (memReqOut/ramAddrOut/memGrantIn/ramDataIn) and present it as a one-cycle fill (memDataValid/memAddr/memDataOut); busyOut while not IDLE
module icache_refill import icache_refill_pkg::*; #(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
  parameter int BLOCK_SIZE = 2 ** BLOCK_WIDTH
) (
  input  logic                              clkIn,
  input  logic                              resetIn,
  input  logic                              missIn,
  input  logic [ADDR_WIDTH-1:0]             instrAddrIn,
  input  logic                              memGrantIn,
  input  logic [7:0]                        ramDataIn,
  output logic                              memReqOut,
  output logic [ADDR_WIDTH-1:0]             ramAddrOut,
  output logic                              memDataValid,
  output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] memAddr,
  output logic [BLOCK_SIZE*8-1:0]           memDataOut,
  output logic                              busyOut
);
  state_e state_q, state_d;
  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] blk_q, blk_d, maddr_q;
  logic [BLOCK_WIDTH:0] issue_q, issue_d, recv_q, recv_d;
  logic [BLOCK_SIZE*8-1:0] block, data_q;
  logic iss_q, start, issue, recv, unused_low;
  assign unused_low = ^instrAddrIn[BLOCK_WIDTH-1:0];
  assign start = state_q == IDLE && missIn;
  assign issue = state_q == FETCH && memGrantIn;
  assign recv = iss_q && (state_q == FETCH || state_q == DRAIN);
  always_comb begin
    blk_d = start ? instrAddrIn[ADDR_WIDTH-1:BLOCK_WIDTH] : blk_q;
    issue_d = start ? '0 : issue ? issue_q + 1'b1 : issue_q;
    recv_d = start ? '0 : recv ? recv_q + 1'b1 : recv_q;
    state_d = state_q == IDLE  ? (missIn ? FETCH : IDLE) :
              state_q == FETCH ? (issue && issue_q[BLOCK_WIDTH-1:0] == '1 ? DRAIN : FETCH) :
              state_q == DRAIN ? (recv_d[BLOCK_WIDTH] ? FILL : DRAIN) :
              state_q == FILL  ? COOL : IDLE;
  end
  always_ff @(posedge clkIn) begin
    if (resetIn) begin
      state_q <= IDLE;
      blk_q <= '0;
      issue_q <= '0;
      recv_q <= '0;
      iss_q <= 1'b0;
      data_q <= '0;
      maddr_q <= '0;
    end else begin
      state_q <= state_d;
      blk_q <= blk_d;
      issue_q <= issue_d;
      recv_q <= recv_d;
      iss_q <= issue;
      data_q <= memDataOut;
      maddr_q <= memAddr;
    end
  end
  block_assembler #(.BLOCK_WIDTH(BLOCK_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_asm (
    .clk_i  (clkIn),
    .rst_i  (resetIn),
    .we_i   (recv),
    .idx_i  (recv_q[BLOCK_WIDTH-1:0]),
    .byte_i (ramDataIn),
    .block_o(block)
  );
  assign memReqOut = state_q == FETCH;
  assign ramAddrOut = memReqOut ? {blk_q, issue_q[BLOCK_WIDTH-1:0]} : '0;
  assign memDataValid = state_q == FILL;
  assign memAddr = memDataValid ? blk_q : maddr_q;
  assign memDataOut = memDataValid ? block : data_q;
  assign busyOut = state_q != IDLE;
endmodule
